// File: rtl/dds_phase_accumulator.sv
// dds_phase_accumulator: CDC-safe step capture, phase accumulation and quarter-wave sine lookup
module dds_phase_accumulator #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter logic [PHASE_W-1:0] RESET_STEP = 171798691
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PHASE_W-1:0]  step_in,
  input  logic [PHASE_W-1:0]  phase_offset,
  input  logic                en,
  input  logic                sync_clear,
  output logic [ADDR_W-3:0]   rom_addr,
  input  logic [DATA_W-2:0]   rom_data,
  output logic [DATA_W-1:0]   sample,
  output logic                sample_valid,
  output logic                wrap_pulse,
  output logic                msb_tick
);
  localparam int LOW_W = PHASE_W - ADDR_W;
  logic [PHASE_W-1:0] s1, s2, step_reg, acc, acc_next;
  logic [ADDR_W-1:0] idx, phase_top;
  logic [DATA_W-1:0] mag;
  logic [3:0] vld;
  logic carry, low_carry, acc_msb_d, neg_d, neg_dd, upd;
  always_comb begin
    {carry, acc_next} = {1'b0, acc} + {1'b0, step_reg};
    upd = en & ~sync_clear;
    // only the table index of acc+phase_offset is needed; the low half contributes just its carry
    low_carry = (acc[LOW_W-1:0] + phase_offset[LOW_W-1:0]) < acc[LOW_W-1:0];
    phase_top = acc[PHASE_W-1 -: ADDR_W] + phase_offset[PHASE_W-1 -: ADDR_W] + {{(ADDR_W-1){1'b0}}, low_carry};
    mag = {1'b0, rom_data};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= RESET_STEP;
      s2 <= RESET_STEP;
      step_reg <= RESET_STEP;
      acc <= '0;
      wrap_pulse <= 1'b0;
      acc_msb_d <= 1'b0;
      msb_tick <= 1'b0;
      idx <= '0;
      rom_addr <= '0;
      neg_d <= 1'b0;
      neg_dd <= 1'b0;
      sample <= '0;
      vld <= '0;
      sample_valid <= 1'b0;
    end else begin
      s1 <= step_in;
      s2 <= s1;
      if (s1 == s2) step_reg <= s2;
      acc <= sync_clear ? '0 : en ? acc_next : acc;
      wrap_pulse <= upd & carry;
      acc_msb_d <= acc[PHASE_W-1];
      msb_tick <= acc[PHASE_W-1] & ~acc_msb_d;
      idx <= phase_top;
      rom_addr <= idx[ADDR_W-2] ? ~idx[ADDR_W-3:0] : idx[ADDR_W-3:0];
      neg_d <= idx[ADDR_W-1];
      neg_dd <= neg_d;
      sample <= neg_dd ? -mag : mag;
      vld <= {vld[2:0], upd};
      sample_valid <= vld[3];
    end
endmodule
